lbist_seq_ctrl: RTL

//  Top-level LBIST sequencer. On start: seeds the pattern LFSR, clears the MISR,

---
 rtl/lbist_seq_ctrl_pkg.sv | 54 +++++
 rtl/lbist_seq_ctrl_cycle_cnt.sv | 31 +++
 rtl/lbist_seq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lbist_seq_ctrl_pkg.sv
// Shared definitions for the LBIST sequencer: state encoding, default
// parameter values used by the LFSR/MISR/comp siblings, and small helpers.
package lbist_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } lbist_state_e;

  localparam int LBIST_RC_BITS    = 8;
  localparam int LBIST_N_PATTERNS = 255;
  localparam int LBIST_PIPE_DEPTH = 1;
  localparam int LBIST_CMP_LAT    = 1;

  // One bit per control strobe, all decoded purely from a state value.
  typedef struct packed {
    logic lfsr_load;
    logic lfsr_en;
    logic misr_clr;
    logic misr_en;
    logic busy;
    logic done;
  } strobe_t;

  // Width of the shared counter: must hold the largest reload value.
  function automatic int lbist_cnt_width(int n, int d, int l);
    int m;
    m = n;
    if (d > m) m = d;
    if (l > m) m = l;
    return $clog2(m + 1);
  endfunction

  // Moore decode of the control strobes for a given state.
  function automatic strobe_t lbist_decode(lbist_state_e st);
    strobe_t s;
    s = '0;
    case (st)
      ST_IDLE:  s = '0;
      ST_INIT:  begin s.lfsr_load = 1'b1; s.misr_clr = 1'b1; s.busy = 1'b1; end
      ST_RUN:   begin s.lfsr_en = 1'b1; s.misr_en = 1'b1; s.busy = 1'b1; end
      ST_FLUSH: begin s.misr_en = 1'b1; s.busy = 1'b1; end
      ST_CMP:   s.busy = 1'b1;
      ST_DONE:  s.done = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lbist_seq_ctrl_cycle_cnt.sv
// Loadable down-counter shared by the RUN, FLUSH and CMP phases.
// Load has priority over decrement; the caller never decrements at zero.
module lbist_cycle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Count register: reload, step down, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {W{1'b0}});

endmodule

// File: rtl/lbist_seq_ctrl.sv
// LBIST sequencer: seeds the LFSR, clears the MISR, applies N_PATTERNS,
// flushes the CUT pipeline, snapshots the signature and latches the
// comparator verdict. All outputs are registered copies of the state decode.
module lbist_seq_ctrl
  import lbist_seq_ctrl_pkg::*;
#(
  parameter int RC_BITS    = LBIST_RC_BITS,
  parameter int N_PATTERNS = LBIST_N_PATTERNS,
  parameter int PIPE_DEPTH = LBIST_PIPE_DEPTH,
  parameter int CMP_LAT    = LBIST_CMP_LAT,
  parameter int CNT_W      = lbist_cnt_width(N_PATTERNS, PIPE_DEPTH, CMP_LAT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [RC_BITS-1:0] golden,
  input  logic [RC_BITS-1:0] misr_sig,
  input  logic               cmp_res,
  output logic               lfsr_load,
  output logic               lfsr_en,
  output logic               misr_clr,
  output logic               misr_en,
  output logic [RC_BITS-1:0] cmp_a,
  output logic [RC_BITS-1:0] cmp_b,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  localparam logic [CNT_W-1:0] LD_RUN   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LD_FLUSH = (PIPE_DEPTH > 0) ? CNT_W'(PIPE_DEPTH - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LD_CMP   = CNT_W'(CMP_LAT - 1);

  lbist_state_e       state;
  lbist_state_e       state_nxt;
  strobe_t            strb_q;
  logic [RC_BITS-1:0] sig_q;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;

  lbist_cycle_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state and counter control; abort from any busy/done state wins.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = {CNT_W{1'b0}};
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) state_nxt = ST_INIT;
          else                 state_nxt = ST_IDLE;
        end
        ST_INIT: begin
          state_nxt = ST_RUN;
          cnt_load  = 1'b1;
          cnt_val   = LD_RUN;
        end
        ST_RUN: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            if (PIPE_DEPTH > 0) begin
              state_nxt = ST_FLUSH;
              cnt_val   = LD_FLUSH;
            end else begin
              state_nxt = ST_CMP;
              cnt_val   = LD_CMP;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_zero) begin
            state_nxt = ST_CMP;
            cnt_load  = 1'b1;
            cnt_val   = LD_CMP;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_CMP: begin
          if (cnt_zero) state_nxt = ST_DONE;
          else          cnt_dec   = 1'b1;
        end
        ST_DONE: begin
          if (start) state_nxt = ST_INIT;
          else       state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, registered strobes, signature snapshot and verdict latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      strb_q <= '0;
      sig_q  <= {RC_BITS{1'b0}};
      pass   <= 1'b0;
    end else begin
      state  <= state_nxt;
      strb_q <= lbist_decode(state_nxt);
      if ((state != ST_CMP) && (state_nxt == ST_CMP)) sig_q <= misr_sig;
      else                                            sig_q <= sig_q;
      if ((state == ST_CMP) && (state_nxt == ST_DONE)) pass <= cmp_res;
      else if (state_nxt == ST_DONE)                   pass <= pass;
      else                                             pass <= 1'b0;
    end
  end

  assign lfsr_load = strb_q.lfsr_load;
  assign lfsr_en   = strb_q.lfsr_en;
  assign misr_clr  = strb_q.misr_clr;
  assign misr_en   = strb_q.misr_en;
  assign busy      = strb_q.busy;
  assign done      = strb_q.done;
  assign cmp_a     = sig_q;
  assign cmp_b     = golden;

endmodule
